// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter: op encoding, flag bit
// positions and the per-requester response slot layout.
package alu_arb_pkg;

   typedef enum logic [4:0] {
      ADD  = 5'd0,
      SUB  = 5'd1,
      AND  = 5'd2,
      OR   = 5'd3,
      XOR  = 5'd4,
      SLT  = 5'd5,
      SLTU = 5'd6,
      SLL  = 5'd7,
      SRA  = 5'd8,
      SRL  = 5'd9
   } alu_op_e;

   localparam int OP_MAX = 9;

   localparam int FLAG_ZERO = 6;
   localparam int FLAG_BEQ  = 5;
   localparam int FLAG_BNE  = 4;
   localparam int FLAG_BLT  = 3;
   localparam int FLAG_BGE  = 2;
   localparam int FLAG_BLTU = 1;
   localparam int FLAG_BGEU = 0;

   // Slot storage width; the arbiter's W/NFLAG must not exceed these.
   localparam int RSP_W     = 32;
   localparam int RSP_NFLAG = 7;

   typedef struct packed {
      logic [RSP_W-1:0]     result;
      logic [RSP_NFLAG-1:0] flags;
      logic                 err;
   } rsp_t;

   function automatic logic op_illegal(input logic [4:0] op);
      return op > 5'(OP_MAX);
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin grant: first eligible requester after the last-served one,
// searched cyclically; at most one grant.
module rr_arbiter #(
   parameter int  NREQ = 2,
   localparam int LW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] eligible,
   input  logic [LW-1:0]   last,
   output logic [NREQ-1:0] grant,
   output logic [LW-1:0]   gidx,
   output logic            any
);

   always_comb begin
      int idx;
      grant = '0;
      gidx  = '0;
      any   = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last) + k) % NREQ;
         if (!any && eligible[idx]) begin
            grant[idx] = 1'b1;
            gidx       = LW'(idx);
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters with round-robin grant and
// one registered response slot per requester. ALU_ARB_STATS_EN adds grant/conflict counters.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int W     = 32,
   parameter int NFLAG = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*W-1:0]     req_a,
   input  logic [NREQ*W-1:0]     req_b,
   input  logic [NREQ*5-1:0]     req_op,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [NREQ*W-1:0]     rsp_result,
   output logic [NREQ*NFLAG-1:0] rsp_flags,
   output logic [NREQ-1:0]       rsp_err,
   output logic [W-1:0]          alu_a,
   output logic [W-1:0]          alu_b,
   output logic [4:0]            alu_ctrl,
   input  logic [W-1:0]          alu_result,
   input  logic [NFLAG-1:0]      alu_flags
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [31:0]           stat_ops,
   output logic [31:0]           stat_conflict
`endif
);

   localparam int LW = $clog2(NREQ);

   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] grant;
   logic [LW-1:0]   gidx;
   logic            gnt_any;
   logic [W-1:0]    sel_a;
   logic [W-1:0]    sel_b;
   logic [4:0]      sel_op;
   logic            sel_bad;
   rsp_t            cap;

   logic [NREQ-1:0] rsp_vld_p1;
   logic [LW-1:0]   last_p1;
   rsp_t            slot_p1 [NREQ];

   // A full slot being drained this cycle may be refilled in the same cycle.
   assign eligible  = req_valid & (~rsp_vld_p1 | rsp_ready);
   assign req_ready = grant;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .eligible (eligible),
      .last     (last_p1),
      .grant    (grant),
      .gidx     (gidx),
      .any      (gnt_any)
   );

   always_comb begin
      sel_a   = req_a[int'(gidx)*W +: W];
      sel_b   = req_b[int'(gidx)*W +: W];
      sel_op  = req_op[int'(gidx)*5 +: 5];
      sel_bad = op_illegal(sel_op);
      alu_a    = '0;
      alu_b    = '0;
      alu_ctrl = '0;
      if (gnt_any) begin
         alu_a = sel_a;
         alu_b = sel_b;
         if (!sel_bad) alu_ctrl = sel_op;
      end
      cap.result = sel_bad ? '0 : RSP_W'(alu_result);
      cap.flags  = sel_bad ? '0 : RSP_NFLAG'(alu_flags);
      cap.err    = sel_bad;
   end

   // ---- stage p1: response slots and round-robin pointer ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_vld_p1 <= '0;
         last_p1    <= LW'(NREQ-1);
         for (int i = 0; i < NREQ; i++) slot_p1[i] <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
               rsp_vld_p1[i] <= 1'b1;
               slot_p1[i]    <= cap;
            end else if (rsp_ready[i]) begin
               rsp_vld_p1[i] <= 1'b0;
            end
         end
         if (gnt_any) last_p1 <= gidx;
      end
   end

   assign rsp_valid = rsp_vld_p1;

   for (genvar g = 0; g < NREQ; g++) begin : g_out
      assign rsp_result[g*W +: W]         = W'(slot_p1[g].result);
      assign rsp_flags[g*NFLAG +: NFLAG]  = NFLAG'(slot_p1[g].flags);
      assign rsp_err[g]                   = slot_p1[g].err;
   end

`ifdef ALU_ARB_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_ops      <= '0;
         stat_conflict <= '0;
      end else begin
         if (gnt_any) stat_ops <= stat_ops + 32'd1;
         if ($countones(eligible) > 1) stat_conflict <= stat_conflict + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and a response scoreboard.
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   logic        clk;
   logic        reset;
   logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
   logic [63:0] req_a, req_b, rsp_result;
   logic [9:0]  req_op;
   logic [13:0] rsp_flags;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [4:0]  alu_ctrl;
   logic [6:0]  alu_flags;
`ifdef ALU_ARB_STATS_EN
   logic [31:0] stat_ops, stat_conflict;
   int          exp_ops, exp_conf;
`endif

   typedef struct {
      int          port;
      logic [31:0] res;
      logic [6:0]  fl;
      logic        err;
   } exp_t;

   exp_t       sbq [$];
   logic [1:0] prev_vld;
   int         n_chk, n_pass, n_fail;

   alu_arbiter dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_flags(alu_flags)
`ifdef ALU_ARB_STATS_EN
      , .stat_ops(stat_ops), .stat_conflict(stat_conflict)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [38:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [4:0] op);
      logic [31:0] r;
      logic        slt, ult;
      slt = $signed(a) < $signed(b);
      ult = a < b;
      case (op)
         5'd0: r = a + b;
         5'd1: r = a - b;
         5'd2: r = a & b;
         5'd3: r = a | b;
         5'd4: r = a ^ b;
         5'd5: r = {31'd0, slt};
         5'd6: r = {31'd0, ult};
         5'd7: r = a << b[4:0];
         5'd8: r = 32'($signed(a) >>> b[4:0]);
         5'd9: r = a >> b[4:0];
         default: r = '0;
      endcase
      return {r, (r == 32'd0), (a == b), (a != b), slt, !slt, ult, !ult};
   endfunction

   always_comb {alu_result, alu_flags} = alu_model(alu_a, alu_b, alu_ctrl);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic [1:0] v, input logic [1:0] rr,
                      input logic [31:0] a0, input logic [31:0] b0, input logic [4:0] op0,
                      input logic [31:0] a1, input logic [31:0] b1, input logic [4:0] op1);
      @(negedge clk);
      req_valid = v;
      rsp_ready = rr;
      req_a     = {a1, a0};
      req_b     = {b1, b0};
      req_op    = {op1, op0};
   endtask

   // Checks the grant cycle, then the registered responses one edge later.
   task automatic go(input string tag, input logic [1:0] exp_rdy, input logic [1:0] exp_vld);
      exp_t        e;
      int          p;
      logic [4:0]  op;
      logic [31:0] a, b;
      #1;
`ifdef ALU_ARB_STATS_EN
      if ($countones(req_valid & (~prev_vld | rsp_ready)) > 1) exp_conf++;
      if (exp_rdy != 2'b00) exp_ops++;
`endif
      chk($sformatf("%s.ready", tag), 64'(req_ready), 64'(exp_rdy));
      if (exp_rdy != 2'b00) begin
         p  = exp_rdy[1] ? 1 : 0;
         op = req_op[p*5 +: 5];
         a  = req_a[p*32 +: 32];
         b  = req_b[p*32 +: 32];
         chk($sformatf("%s.alu_a", tag), 64'(alu_a), 64'(a));
         chk($sformatf("%s.alu_ctrl", tag), 64'(alu_ctrl), 64'((op > 5'd9) ? 5'd0 : op));
         e.port = p;
         e.err  = op > 5'd9;
         {e.res, e.fl} = e.err ? 39'd0 : alu_model(a, b, op);
         sbq.push_back(e);
      end else begin
         chk($sformatf("%s.alu_idle", tag), {alu_a, 27'd0, alu_ctrl}, 64'd0);
      end
      @(posedge clk);
      #1;
      chk($sformatf("%s.rsp_valid", tag), 64'(rsp_valid), 64'(exp_vld));
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk($sformatf("%s.result%0d", tag, e.port), 64'(rsp_result[e.port*32 +: 32]), 64'(e.res));
         chk($sformatf("%s.flags%0d", tag, e.port), 64'(rsp_flags[e.port*7 +: 7]), 64'(e.fl));
         chk($sformatf("%s.err%0d", tag, e.port), 64'(rsp_err[e.port]), 64'(e.err));
      end
      prev_vld = exp_vld;
`ifdef ALU_ARB_STATS_EN
      chk($sformatf("%s.stat_ops", tag), 64'(stat_ops), 64'(exp_ops));
      chk($sformatf("%s.stat_conflict", tag), 64'(stat_conflict), 64'(exp_conf));
`endif
   endtask

   initial begin
      n_chk = 0; n_pass = 0; n_fail = 0;
      prev_vld  = 2'b00;
      reset     = 1'b1;
      req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_op = '0;
`ifdef ALU_ARB_STATS_EN
      exp_ops = 0; exp_conf = 0;
`endif
      @(posedge clk);
      #1;
      chk("reset.valid", 64'(rsp_valid), 64'd0);
      chk("reset.result", rsp_result, 64'd0);
      chk("reset.flags_err", {48'd0, rsp_flags, rsp_err}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // single op on port 0
      drv(2'b01, 2'b11, 32'd5, 32'd7, 5'd0, 32'd0, 32'd0, 5'd0);
      go("single", 2'b01, 2'b01);
      chk("single.sum", 64'(rsp_result[31:0]), 64'd12);
      chk("single.blt", 64'(rsp_flags[FLAG_BLT]), 64'd1);
      chk("single.zero", 64'(rsp_flags[FLAG_ZERO]), 64'd0);
      drv(2'b00, 2'b11, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0);
      go("idle", 2'b00, 2'b00);

      // contention: port 0 was served last, so port 1 leads
      drv(2'b11, 2'b11, 32'd100, 32'd30, 5'd1, 32'h0000F0F0, 32'h00000FF0, 5'd3);
      go("cont1", 2'b10, 2'b10);
      drv(2'b11, 2'b11, 32'd100, 32'd30, 5'd1, 32'hAAAA5555, 32'hFFFF0000, 5'd4);
      go("cont2", 2'b01, 2'b01);
      drv(2'b11, 2'b11, 32'hFF00FF00, 32'h0F0F0F0F, 5'd2, 32'hAAAA5555, 32'hFFFF0000, 5'd4);
      go("cont3", 2'b10, 2'b10);
      drv(2'b11, 2'b11, 32'hFF00FF00, 32'h0F0F0F0F, 5'd2, 32'd7, 32'd3, 5'd7);
      go("cont4", 2'b01, 2'b01);

      // backpressure on port 0's pending response
      drv(2'b11, 2'b00, 32'd9, 32'd9, 5'd1, 32'd7, 32'd3, 5'd7);
      go("bp1", 2'b10, 2'b11);
      drv(2'b01, 2'b10, 32'd9, 32'd9, 5'd1, 32'd7, 32'd3, 5'd7);
      go("bp2", 2'b00, 2'b01);
      drv(2'b01, 2'b01, 32'd9, 32'd9, 5'd1, 32'd7, 32'd3, 5'd7);
      go("bp3", 2'b01, 2'b01);
      chk("bp3.zero", 64'(rsp_flags[FLAG_ZERO]), 64'd1);

      // illegal op on port 1
      drv(2'b10, 2'b11, 32'd0, 32'd0, 5'd0, 32'd3, 32'd3, 5'd12);
      go("illegal", 2'b10, 2'b10);
      chk("illegal.err", 64'(rsp_err[1]), 64'd1);

      // branch flags from a signed/unsigned disagreement
      drv(2'b01, 2'b11, 32'hFFFFFFFF, 32'd1, 5'd1, 32'd0, 32'd0, 5'd0);
      go("flags", 2'b01, 2'b01);
      chk("flags.result", 64'(rsp_result[31:0]), 64'hFFFFFFFE);
      chk("flags.bits", 64'({rsp_flags[FLAG_BLT], rsp_flags[FLAG_BLTU],
                             rsp_flags[FLAG_BGEU], rsp_flags[FLAG_BNE]}), 64'b1011);

      // shifts and set-less-than
      drv(2'b10, 2'b11, 32'd0, 32'd0, 5'd0, 32'h80000010, 32'd4, 5'd8);
      go("sra", 2'b10, 2'b10);
      drv(2'b01, 2'b11, 32'h80000010, 32'd4, 5'd9, 32'd0, 32'd0, 5'd0);
      go("srl", 2'b01, 2'b01);
      drv(2'b10, 2'b11, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFE, 32'd3, 5'd5);
      go("slt", 2'b10, 2'b10);
      drv(2'b01, 2'b11, 32'hFFFFFFFE, 32'd3, 5'd6, 32'd0, 32'd0, 5'd0);
      go("sltu", 2'b01, 2'b01);

      // asynchronous reset with port 0's response pending
      drv(2'b11, 2'b11, 32'd11, 32'd4, 5'd4, 32'd20, 32'd6, 5'd0);
      reset = 1'b1;
      #1;
      chk("mid_reset.valid", 64'(rsp_valid), 64'd0);
      chk("mid_reset.result", rsp_result, 64'd0);
      chk("mid_reset.flags_err", {48'd0, rsp_flags, rsp_err}, 64'd0);
      sbq.delete();
      prev_vld = 2'b00;
`ifdef ALU_ARB_STATS_EN
      exp_ops = 0; exp_conf = 0;
`endif
      @(negedge clk);
      reset = 1'b0;
      go("post_reset0", 2'b01, 2'b01);
      drv(2'b11, 2'b11, 32'd1, 32'd2, 5'd0, 32'd20, 32'd6, 5'd0);
      go("post_reset1", 2'b10, 2'b10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU (5-bit aluControl encoding: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 sra, 9 srl) between NREQ requesters, e.g. the core datapath and an address/debug unit.
- Uses round-robin arbitration and a valid/ready request handshake.
- Registers the result and the branch flags into one response slot per requester.
- Sits between the requesters and the ALU instance. The ALU itself stays unchanged.

Parameters:
- NREQ, 2, number of requesters (2..4).
- W, 32, operand/result width.
- NFLAG, 7, flag vector width, ordered {zero, beq, bne, blt, bge, bltu, bgeu} (bit 6 = zero).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  request present, one bit per requester.
- req_ready  output  NREQ  request accepted this cycle (one-hot or zero).
- req_a  input  NREQ*W  operand A per requester.
- req_b  input  NREQ*W  operand B per requester.
- req_op  input  NREQ*5  aluControl per requester.
- rsp_valid  output  NREQ  response slot full.
- rsp_ready  input  NREQ  requester consumes its response.
- rsp_result  output  NREQ*W  registered ALU result.
- rsp_flags  output  NREQ*NFLAG  registered flags.
- rsp_err  output  NREQ  op code was illegal (>9).
- alu_a  output  W  to ALU operand A.
- alu_b  output  W  to ALU operand B.
- alu_ctrl  output  5  to ALU aluControl.
- alu_result  input  W  from ALU.
- alu_flags  input  NFLAG  from ALU flags.

Behaviour:
- Reset: one clock; asynchronous, active-high reset.
  - On reset, all rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0.
  - The round-robin pointer last=NREQ-1, so port 0 wins first.
  - Reset mid-operation drops pending responses; nothing is replayed.
- Eligibility: eligible[i] = req_valid[i] && (!rsp_valid[i] || rsp_ready[i]).
  - Each requester has at most one outstanding response.
  - A slot consumed in the same cycle permits back-to-back issue.
- Grant: pick the first eligible port after last, cyclically. At most one grant per cycle.
  - req_ready = grant, combinational from req_valid/rsp state.
  - Requesters must hold req_* stable while req_valid && !req_ready.
- ALU drive:
  - With a grant: alu_a/alu_b/alu_ctrl = the granted port's operands.
  - Otherwise: alu_a=0, alu_b=0, alu_ctrl=0, so the ALU sees no X.
  - If the granted op >9, alu_ctrl is forced to 0.
- Capture on the grant edge into slot g:
  - rsp_valid[g]=1.
  - rsp_result[g]=alu_result, or 0 if the op was illegal.
  - rsp_flags[g]=alu_flags, or 0 if illegal.
  - rsp_err[g]=(op>9).
  - last=g.
- Latency: request accepted in cycle N gives rsp_valid in cycle N+1.
- Throughput: one op per cycle total.
- Slot clear: rsp_valid[i] clears on rsp_ready[i] unless the same cycle refills it.
  - rsp_result/rsp_flags/rsp_err hold their last values after clear.
- No grant: last is unchanged.
- Simultaneous valid from all ports: service is strictly rotating. Each port waits at most NREQ-1 cycles once eligible.
- rsp_ready while !rsp_valid: ignored.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined, adds outputs:
  - stat_ops, 32-bit: counts grants.
  - stat_conflict, 32-bit: counts cycles where more than one port was eligible.
  - Both reset to 0 and wrap at 2^32-1 to 0.
- When undefined, these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package alu_arb_pkg holds:
  - alu_op_e enum (ADD=0..SRL=9).
  - OP_MAX=9.
  - flag bit index constants (FLAG_ZERO=6..FLAG_BGEU=0).
  - rsp_t struct {result, flags, err}.
- One sub-module, rr_arbiter (NREQ-wide round-robin grant from eligible + last pointer).
- Response slots are generated inline.

Test Plan:
- Single op: port0 valid, op=0, a=5, b=7 -> req_ready[0]=1 in cycle N. In N+1: rsp_valid[0]=1, rsp_result[0]=12, flags zero=0, blt=1.
- Contention: both ports valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1. stat_conflict increments every cycle with ALU_ARB_STATS_EN.
- Backpressure: port0 rsp_ready=0 with a response pending, port0 valid again -> port0 not granted. Port1 is served alone. Port0 is regranted the cycle its rsp_ready=1.
- Illegal op: port1 op=12, a=3, b=3 -> rsp_err[1]=1, rsp_result[1]=0, rsp_flags[1]=0, alu_ctrl driven 0.
- Flags: op=1, a=-1 (0xFFFFFFFF), b=1 -> result 0xFFFFFFFE, blt=1, bltu=0, bgeu=1, bne=1.
- Reset mid-op: assert reset while rsp_valid[0]=1 -> rsp_valid=0 immediately (asynchronous). After release with both ports valid, port0 is granted first.
